demux_1to4_buf: RTL and testbench

Registered 1-to-4 demultiplexer with a valid/ready handshake on the input and on each of four output channels. One input word is steered by `select_i` into a one-entry holding register per channel; each channel drains independently. This is the distribution counterpart to the 4-to-1 select mux: it fans one producer out to four consumers of a `size`-bit datapath.

---
 rtl/demux_1to4_buf.sv | 75 +++++++
 tb/tb_demux_1to4_buf.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_buf.sv
// Registered 1-to-4 demultiplexer: one valid/ready input steered into four
// independent one-entry channel buffers, each drained by its own consumer.

module demux_1to4_buf_chan #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            ld,
    input  logic            drn,
    input  logic [size-1:0] din,
    output logic [size-1:0] dout,
    output logic            vld
);
    // A load wins over a drain so a full channel can refill in the cycle it empties.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld  <= 1'b0;
            dout <= '0;
        end else if (ld) begin
            vld  <= 1'b1;
            dout <= din;
        end else if (drn) begin
            vld  <= 1'b0;
        end
    end
endmodule

module demux_1to4_buf #(
    parameter int size = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [size-1:0] data_i,
    input  logic [1:0]      select_i,
    input  logic            valid_i,
    output logic            ready_o,
    output logic [size-1:0] data0_o,
    output logic [size-1:0] data1_o,
    output logic [size-1:0] data2_o,
    output logic [size-1:0] data3_o,
    output logic [3:0]      valid_o,
    input  logic [3:0]      ready_i
);
    localparam int NUM_CH = 4;

    logic                           acc;
    logic [NUM_CH-1:0]              ld;
    logic [NUM_CH-1:0]              drn;
    logic [NUM_CH-1:0][size-1:0]    data;

    // Only the addressed channel gates acceptance; the others never stall the producer.
    assign ready_o = ~valid_o[select_i] | ready_i[select_i];
    assign acc     = valid_i & ready_o;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
        assign ld[k]  = acc & (select_i == 2'(k));
        assign drn[k] = valid_o[k] & ready_i[k];

        demux_1to4_buf_chan #(.size(size)) u_chan (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .ld    (ld[k]),
            .drn   (drn[k]),
            .din   (data_i),
            .dout  (data[k]),
            .vld   (valid_o[k])
        );
    end

    assign data0_o = data[0];
    assign data1_o = data[1];
    assign data2_o = data[2];
    assign data3_o = data[3];
endmodule

// File: tb/tb_demux_1to4_buf.sv
// Directed bench for demux_1to4_buf: a negedge monitor scores every channel
// against per-channel expectation queues filled as words are issued.

module tb_demux_1to4_buf;
    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic [31:0] data_i = '0;
    logic [1:0]  select_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] data0_o, data1_o, data2_o, data3_o;
    logic [3:0]  valid_o;
    logic [3:0]  ready_i = '0;

    int total = 0;
    int bad = 0;
    int cnt_a = 0;
    bit mon_en = 1'b0;
    logic [31:0] sb[4][$];

    demux_1to4_buf #(.size(32)) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .data_i   (data_i),
        .select_i (select_i),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .data0_o  (data0_o),
        .data1_o  (data1_o),
        .data2_o  (data2_o),
        .data3_o  (data3_o),
        .valid_o  (valid_o),
        .ready_i  (ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        valid_i = v; select_i = s; data_i = d; ready_i = r;
        @(posedge clk); #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [31:0] d, input logic [3:0] r);
        valid_i = v; select_i = s; data_i = d; ready_i = r;
        #1;
    endtask

    // Scoreboard monitor: front of sb[k] is the word channel k must be showing.
    always @(negedge clk) begin : mon
        logic [31:0] dv [4];
        logic [31:0] w;
        bit          exp_rdy;
        if (mon_en) begin
            dv[0] = data0_o; dv[1] = data1_o; dv[2] = data2_o; dv[3] = data3_o;
            for (int k = 0; k < 4; k++) begin
                if (sb[k].size() != 0) begin
                    chk($sformatf("mon_valid%0d", k), {31'b0, valid_o[k]}, 32'd1);
                    chk($sformatf("mon_data%0d", k), dv[k], sb[k][0]);
                end else begin
                    chk($sformatf("mon_valid%0d", k), {31'b0, valid_o[k]}, 32'd0);
                end
            end
            exp_rdy = (sb[select_i].size() == 0) || ready_i[select_i];
            chk("mon_ready", {31'b0, ready_o}, {31'b0, exp_rdy});
            if (rst_i) begin
                for (int k = 0; k < 4; k++) sb[k].delete();
            end else begin
                for (int k = 0; k < 4; k++) begin
                    if (sb[k].size() != 0 && ready_i[k]) begin
                        w = sb[k].pop_front();
                        if (k == 0 && w == 32'hA) cnt_a++;
                    end
                end
                if (valid_i && exp_rdy) sb[select_i].push_back(data_i);
            end
        end
    end

    initial begin
        // Reset with a live-looking input: nothing may load.
        rst_i = 1'b1;
        step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
        step(1'b1, 2'd2, 32'hDEADBEEF, 4'b0000);
        rst_i = 1'b0;
        drive(1'b0, 2'd2, 32'h0, 4'b0000);
        chk("rst_valid", {28'b0, valid_o}, 32'h0);
        chk("rst_d0", data0_o, 32'h0);
        chk("rst_d1", data1_o, 32'h0);
        chk("rst_d2", data2_o, 32'h0);
        chk("rst_d3", data3_o, 32'h0);
        chk("rst_ready", {31'b0, ready_o}, 32'd1);
        mon_en = 1'b1;

        // Fan-out to all four channels, no consumers ready.
        step(1'b1, 2'd0, 32'h11, 4'b0000);
        step(1'b1, 2'd1, 32'h22, 4'b0000);
        step(1'b1, 2'd2, 32'h33, 4'b0000);
        step(1'b1, 2'd3, 32'h44, 4'b0000);
        chk("fan_valid", {28'b0, valid_o}, 32'hF);
        chk("fan_d0", data0_o, 32'h11);
        chk("fan_d1", data1_o, 32'h22);
        chk("fan_d2", data2_o, 32'h33);
        chk("fan_d3", data3_o, 32'h44);
        drive(1'b1, 2'd1, 32'h66, 4'b0000);
        chk("fan_stall_ready", {31'b0, ready_o}, 32'd0);
        step(1'b1, 2'd1, 32'h66, 4'b0000);
        chk("fan_stall_d1", data1_o, 32'h22);
        step(1'b1, 2'd1, 32'h66, 4'b0010);
        chk("fan_held_d1", data1_o, 32'h66);
        chk("fan_held_v", {28'b0, valid_o}, 32'hF);

        // Full-rate stream into channel 2.
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 2'd2, 32'(i), 4'b0100);
            chk($sformatf("rate_ready%0d", i), {31'b0, ready_o}, 32'd1);
            step(1'b1, 2'd2, 32'(i), 4'b0100);
            chk($sformatf("rate_d2_%0d", i), data2_o, 32'(i));
            chk($sformatf("rate_v2_%0d", i), {31'b0, valid_o[2]}, 32'd1);
        end
        step(1'b0, 2'd0, 32'h0, 4'b0100);
        chk("rate_drained", {31'b0, valid_o[2]}, 32'd0);

        // Simultaneous drain and load on channel 0.
        step(1'b0, 2'd0, 32'h0, 4'b0001);
        step(1'b1, 2'd0, 32'hA, 4'b0000);
        chk("sim_d0_a", data0_o, 32'hA);
        drive(1'b1, 2'd0, 32'hB, 4'b0001);
        chk("sim_ready", {31'b0, ready_o}, 32'd1);
        step(1'b1, 2'd0, 32'hB, 4'b0001);
        chk("sim_d0_b", data0_o, 32'hB);
        chk("sim_v0", {31'b0, valid_o[0]}, 32'd1);
        chk("sim_a_once", 32'(cnt_a), 32'd1);

        // Independence: drain ch1 first, then load ch1 while draining ch0, ch3 held.
        step(1'b0, 2'd0, 32'h0, 4'b0010);
        drive(1'b1, 2'd1, 32'h55, 4'b0001);
        chk("ind_ready", {31'b0, ready_o}, 32'd1);
        step(1'b1, 2'd1, 32'h55, 4'b0001);
        chk("ind_d1", data1_o, 32'h55);
        chk("ind_valid", {28'b0, valid_o}, 32'hA);
        chk("ind_d3", data3_o, 32'h44);
        chk("ind_d0_hold", data0_o, 32'hB);
        drive(1'b1, 2'd3, 32'h77, 4'b0000);
        chk("ind_stall_ready", {31'b0, ready_o}, 32'd0);
        step(1'b1, 2'd3, 32'h77, 4'b0000);
        step(1'b1, 2'd3, 32'h77, 4'b0000);
        chk("ind_stall_d3", data3_o, 32'h44);
        drive(1'b1, 2'd3, 32'h77, 4'b1000);
        chk("ind_release_ready", {31'b0, ready_o}, 32'd1);
        step(1'b1, 2'd3, 32'h77, 4'b1000);
        chk("ind_d3_new", data3_o, 32'h77);
        chk("ind_v3", {31'b0, valid_o[3]}, 32'd1);

        // Reset mid-operation with a concurrent load to channel 2.
        step(1'b1, 2'd0, 32'hC, 4'b0000);
        chk("mid_pre_valid", {28'b0, valid_o}, 32'hB);
        rst_i = 1'b1;
        step(1'b1, 2'd2, 32'hDD, 4'b0000);
        rst_i = 1'b0;
        drive(1'b0, 2'd0, 32'h0, 4'b0000);
        chk("mid_valid", {28'b0, valid_o}, 32'h0);
        chk("mid_d0", data0_o, 32'h0);
        chk("mid_d1", data1_o, 32'h0);
        chk("mid_d2", data2_o, 32'h0);
        chk("mid_d3", data3_o, 32'h0);
        step(1'b0, 2'd0, 32'h0, 4'b0000);
        step(1'b0, 2'd0, 32'h0, 4'b0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
